// File: rtl/cern_bus_initiator.sv
// Single-outstanding bus initiator: host cmd -> one-cycle Rd/Wr strobe -> wait for Done or timeout.
// Latency accept->rsp_valid is 2 + wait cycles; cmd_ready low until the response is taken.
module cern_bus_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [17:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [19:2] VMEAddr,
  output logic [31:0] VMEWrData,
  input  logic [31:0] VMERdData,
  output logic        VMERdMem,
  output logic        VMEWrMem,
  input  logic        VMERdDone,
  input  logic        VMEWrDone,
  input  logic        VMERdError,
  input  logic        VMEWrError,
  output logic        busy_o,
  output logic        stray_o
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic        stray_q, stray_d;

  logic done_match;
  logic done_wrong;
  logic expired;

  assign done_match = we_q ? VMEWrDone : VMERdDone;
  assign done_wrong = we_q ? VMERdDone : VMEWrDone;
  assign expired    = (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = STROBE;
      STROBE:  state_d = WAIT;
      WAIT:    if (done_match || expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy_o    = (state_q != IDLE);
    VMERdMem  = (state_q == STROBE) && !we_q;
    VMEWrMem  = (state_q == STROBE) && we_q;
  end

  // Datapath next-state; a matching Done takes priority over expiry
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = to_q;
    stray_d = stray_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_data;
        end
      end
      STROBE: cnt_d = 16'd0;
      WAIT: begin
        if (done_match) begin
          rdata_d = we_q ? 32'd0 : VMERdData;
          err_d   = we_q ? VMEWrError : VMERdError;
          to_d    = 1'b0;
        end else if (expired) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
    if (state_q == WAIT) begin
      if (done_wrong) stray_d = 1'b1;
    end else if (VMERdDone || VMEWrDone) begin
      stray_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      we_q    <= 1'b0;
      addr_q  <= 18'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
      stray_q <= stray_d;
    end
  end

  assign VMEAddr     = addr_q;
  assign VMEWrData   = wdata_q;
  assign rsp_data    = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign stray_o     = stray_q;

endmodule

// File: tb/tb_cern_bus_initiator.sv
// Directed bench for cern_bus_initiator: scoreboard of expected responses checked by a monitor.
module tb_cern_bus_initiator;

  localparam int TO = 16;

  logic        Clk;
  logic        Rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [17:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [19:2] VMEAddr;
  logic [31:0] VMEWrData;
  logic [31:0] VMERdData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic        VMERdDone;
  logic        VMEWrDone;
  logic        VMERdError;
  logic        VMEWrError;
  logic        busy_o;
  logic        stray_o;

  cern_bus_initiator #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdData(VMERdData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .VMERdError(VMERdError), .VMEWrError(VMEWrError),
    .busy_o(busy_o), .stray_o(stray_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [17:0] cur_addr  = '0;
  logic [31:0] cur_wdata = '0;
  int rd_seen = 0, wr_seen = 0;
  int rd_exp  = 0, wr_exp  = 0;

  // responder controls
  int          dly  = -1;
  int          sdly = -1;
  logic [31:0] rdat = '0;
  logic        rerr = 1'b0;
  int          pulse_req = 0;
  int          pulse_ack = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic e, input logic t, input int l);
    exp_t r;
    r.data = d; r.err = e; r.to = t; r.lat = l;
    return r;
  endfunction

  // Responder: Done of the matching kind `dly` cycles after the strobe,
  // optional wrong-kind Done at `sdly`, and on-demand RdDone pulses.
  initial begin : responder
    logic pend;
    logic pwe;
    int   k;
    pend = 1'b0; pwe = 1'b0; k = 0;
    VMERdDone = 0; VMEWrDone = 0; VMERdError = 0; VMEWrError = 0; VMERdData = '0;
    forever begin
      @(posedge Clk);
      #1;
      VMERdDone = 0; VMEWrDone = 0; VMERdError = 0; VMEWrError = 0; VMERdData = '0;
      if (pend) k++;
      if (VMERdMem || VMEWrMem) begin
        pend = 1'b1; pwe = VMEWrMem; k = 0;
      end
      if (pend && k == sdly) begin
        if (pwe) VMERdDone = 1'b1;
        else     VMEWrDone = 1'b1;
      end
      if (pend && k == dly) begin
        if (pwe) begin
          VMEWrDone = 1'b1; VMEWrError = rerr;
        end else begin
          VMERdDone = 1'b1; VMERdError = rerr; VMERdData = rdat;
        end
        pend = 1'b0;
      end
      if (k > 40) pend = 1'b0;
      if (pulse_req != pulse_ack) begin
        VMERdDone = 1'b1;
        pulse_ack++;
      end
    end
  end

  // Monitor: strobe accounting, address/data hold, scoreboard compare
  initial begin : monitor
    exp_t e;
    int   a;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if (VMERdMem) rd_seen++;
        if (VMEWrMem) wr_seen++;
        if (VMERdMem || VMEWrMem) chk("strobe_excl", 32'(VMERdMem & VMEWrMem), 32'd0);
        if (busy_o && !rsp_valid) begin
          chk("addr_hold", 32'(VMEAddr), 32'(cur_addr));
          chk("wdata_hold", VMEWrData, cur_wdata);
        end
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            a = acc_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            if (e.lat >= 0) chk("latency", 32'(cyc - a), 32'(e.lat));
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [17:0] a, input logic [31:0] d,
                       input logic push, input exp_t e, output int acc);
    @(posedge Clk);
    #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (cmd_ready) begin
        acc = cyc;
        cur_addr = a; cur_wdata = d;
        if (push) begin
          sb_q.push_back(e);
          acc_q.push_back(cyc);
        end
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (sb_q.size() == 0 && !busy_o) return;
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_stray"}, 32'(stray_o), 32'd0);
    chk({tag, "_addr"}, 32'(VMEAddr), 32'd0);
    chk({tag, "_wdata"}, VMEWrData, 32'd0);
    chk({tag, "_rdata"}, rsp_data, 32'd0);
    chk({tag, "_err_to"}, {30'd0, rsp_err, rsp_timeout}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, VMERdMem, VMEWrMem}, 32'd0);
  endtask

  initial begin : main
    int a0, a1, a2, acc;
    Rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b1;
    #2;
    chk_reset_vals("por");
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // read, Done one cycle after strobe
    dly = 1; rdat = 32'h00010203; rerr = 0;
    issue(1'b0, 18'h00001, 32'h0, 1'b1, mk(32'h00010203, 0, 0, 3), acc);
    wait_done(); rd_exp++;
    chk("read_strobes", 32'(rd_seen), 32'(rd_exp));

    // write, Done two cycles after strobe
    dly = 2;
    issue(1'b1, 18'h00000, 32'hDEADBEEF, 1'b1, mk(32'h0, 0, 0, 4), acc);
    wait_done(); wr_exp++;
    chk("write_strobes", 32'(wr_seen), 32'(wr_exp));

    // timeout, then Done on the last WAIT cycle
    dly = -1;
    issue(1'b0, 18'h00002, 32'h0, 1'b1, mk(32'h0, 1, 1, TO + 2), acc);
    wait_done(); rd_exp++;
    dly = TO; rdat = 32'h11112222;
    issue(1'b0, 18'h00002, 32'h0, 1'b1, mk(32'h11112222, 0, 0, TO + 2), acc);
    wait_done(); rd_exp++;

    // bus error with response backpressure
    @(posedge Clk); #1 rsp_ready = 1'b0;
    dly = 1; rdat = 32'hCAFEF00D; rerr = 1;
    issue(1'b0, 18'h00003, 32'h0, 1'b1, mk(32'hCAFEF00D, 1, 0, -1), acc);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'hCAFEF00D);
      chk("bp_err", 32'(rsp_err), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge Clk); #1 rsp_ready = 1'b1; rerr = 0;
    wait_done(); rd_exp++;
    chk("stray_clean", 32'(stray_o), 32'd0);

    // back-to-back throughput
    dly = 1; rdat = 32'hA5A50001;
    issue(1'b0, 18'h00010, 32'h0, 1'b1, mk(32'hA5A50001, 0, 0, 3), a0);
    issue(1'b0, 18'h00011, 32'h0, 1'b1, mk(32'hA5A50001, 0, 0, 3), a1);
    issue(1'b0, 18'h00012, 32'h0, 1'b1, mk(32'hA5A50001, 0, 0, 3), a2);
    wait_done(); rd_exp += 3;
    chk("b2b_gap1", 32'(a1 - a0), 32'd4);
    chk("b2b_gap2", 32'(a2 - a1), 32'd4);

    // WrDone during a read
    dly = 3; sdly = 1; rdat = 32'h0BADCAFE;
    issue(1'b0, 18'h00004, 32'h0, 1'b1, mk(32'h0BADCAFE, 0, 0, 5), acc);
    wait_done(); rd_exp++; sdly = -1;
    chk("stray_wrong_done", 32'(stray_o), 32'd1);

    // reset during WAIT, Done arrives after release
    dly = 6;
    issue(1'b0, 18'h2AAAA, 32'h00000055, 1'b0, mk(32'h0, 0, 0, -1), acc);
    rd_exp++;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge Clk); #1 Rst = 1'b0;
    repeat (6) @(negedge Clk);
    chk("stray_late_done", 32'(stray_o), 32'd1);
    chk("no_restrobe", 32'(rd_seen), 32'(rd_exp));
    chk("idle_after_rst", 32'(busy_o), 32'd0);

    // RdDone while idle, then a normal access
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    chk("stray_cleared", 32'(stray_o), 32'd0);
    pulse_req++;
    repeat (3) @(negedge Clk);
    chk("stray_idle_done", 32'(stray_o), 32'd1);
    dly = 1; rdat = 32'h600DF00D;
    issue(1'b0, 18'h00005, 32'h0, 1'b1, mk(32'h600DF00D, 0, 0, 3), acc);
    wait_done(); rd_exp++;
    chk("stray_sticky", 32'(stray_o), 32'd1);
    chk("rd_strobes_total", 32'(rd_seen), 32'(rd_exp));
    chk("wr_strobes_total", 32'(wr_seen), 32'(wr_exp));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
